// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, reset PC default and PC step.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StWait    = 2'd1,
        StIssue   = 2'd2,
        StResolve = 2'd3
    } fetch_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam logic [63:0] PC_INCREMENT     = 64'd4;

endpackage

// File: rtl/next_pc.sv
// Next-PC selection: branch target (word offset scaled to bytes) or sequential PC.
module next_pc
    import instr_fetch_pkg::*;
(
    input  logic [63:0] instr_pc,
    input  logic [63:0] br_offset,
    input  logic        taken,
    output logic [63:0] pc_next
);

    // Both sums wrap modulo 2^64.
    always_comb begin
        if (taken) begin
            pc_next = instr_pc + (br_offset << 2);
        end else begin
            pc_next = instr_pc + PC_INCREMENT;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word, holds it for decode, then waits for branch
// resolution to pick the next PC before fetching again.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [10:0] opcode,
    output logic [63:0] instr_pc,
    input  logic        br_valid,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        zero,
    input  logic [63:0] br_offset,
    output logic [31:0] retired
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [63:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  retired_q, retired_d;
    logic         taken;
    logic [63:0]  pc_next;

    assign taken = uncond_branch | (branch & zero);

    next_pc u_next_pc (
        .instr_pc  (instr_pc_q),
        .br_offset (br_offset),
        .taken     (taken),
        .pc_next   (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        retired_d  = retired_q;
        unique case (state_q)
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (instr_ready) begin
                    state_d = StResolve;
                end
            end
            StResolve: begin
                if (br_valid) begin
                    pc_d    = pc_next;
                    state_d = StFetch;
                    if (retired_q != 32'hFFFF_FFFF) begin
                        retired_d = retired_q + 32'd1;
                    end
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 64'h0;
            retired_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            retired_q  <= retired_d;
        end
    end

    // The request is masked while reset is held so the idle FETCH state never leaks out.
    assign imem_req    = (state_q == StFetch) && !Reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StIssue);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:21];
    assign instr_pc    = instr_pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses are queued when branch
// resolution is driven and compared when the next fetch request appears.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] instr_pc;
    logic        br_valid;
    logic        branch;
    logic        uncond_branch;
    logic        zero;
    logic [63:0] br_offset;
    logic [31:0] retired;

    instr_fetch #(.RESET_PC(64'h0)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .br_valid      (br_valid),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .br_offset     (br_offset),
        .retired       (retired)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_req = 0;
    bit          last_valid = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_pc;
    logic [31:0] ret_exp;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs();
        check("rst_req",     64'(imem_req),    64'd0);
        check("rst_addr",    imem_addr,        64'h0);
        check("rst_valid",   64'(instr_valid), 64'd0);
        check("rst_instr",   64'(instr),       64'd0);
        check("rst_pc",      instr_pc,         64'h0);
        check("rst_retired", 64'(retired),     64'd0);
    endtask

    // Wait (bounded) for the next request and compare it against the scoreboard.
    task automatic fetch_cycle(input bit chk_lat);
        int n = 0;
        step();
        br_valid      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zero          = 1'b0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", 64'(imem_req), 64'd1);
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) cur_pc = exp_q.pop_front();
        check("imem_addr", imem_addr, cur_pc);
        check("retired", 64'(retired), 64'(ret_exp));
        if (chk_lat && last_valid) check("req_interval", 64'(cyc - last_req), 64'd4);
        last_req   = cyc;
        last_valid = 1'b1;
    endtask

    // Called at the negedge where imem_req was seen; carries one instruction to resolution.
    task automatic do_instr(input logic [31:0] word, input int rdy_dly, input bit spurious,
                            input bit preload, input logic br, input logic ub,
                            input logic z, input logic [63:0] off);
        logic [63:0] nxt;
        logic        tk;
        step();
        check("req_pulse", 64'(imem_req), 64'd0);
        if (preload) force dut.retired_q = 32'hFFFF_FFFF;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        if (preload) begin
            release dut.retired_q;
            ret_exp = 32'hFFFF_FFFF;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("instr_valid", 64'(instr_valid), 64'd1);
        check("instr", 64'(instr), 64'(word));
        check("opcode", 64'(opcode), 64'(word[31:21]));
        check("instr_pc", instr_pc, cur_pc);
        for (int i = 0; i < rdy_dly; i++) begin
            if (spurious && i == 0) begin
                br_valid      = 1'b1;
                uncond_branch = 1'b1;
                br_offset     = 64'h40;
            end
            step();
            br_valid      = 1'b0;
            uncond_branch = 1'b0;
            check("hold_valid", 64'(instr_valid), 64'd1);
            check("hold_instr", 64'(instr), 64'(word));
            check("hold_opcode", 64'(opcode), 64'(word[31:21]));
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("valid_drop", 64'(instr_valid), 64'd0);
        tk  = ub | (br & z);
        nxt = tk ? cur_pc + (off << 2) : cur_pc + 64'd4;
        exp_q.push_back(nxt);
        if (ret_exp != 32'hFFFF_FFFF) ret_exp = ret_exp + 32'd1;
        branch        = br;
        uncond_branch = ub;
        zero          = z;
        br_offset     = off;
        br_valid      = 1'b1;
    endtask

    initial begin
        Reset         = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        instr_ready   = 1'b0;
        br_valid      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zero          = 1'b0;
        br_offset     = 64'h0;
        ret_exp       = 32'h0;
        cur_pc        = 64'h0;
        exp_q.push_back(64'h0);

        step();
        check_reset_outputs();
        @(posedge CLK);
        #1 Reset = 1'b0;
        fetch_cycle(1'b0);

        // Sequential run 0,4,8,C; the third is a CBZ that falls through.
        do_instr(32'h8B02_0020, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h123);
        fetch_cycle(1'b1);
        do_instr(32'hCB03_0041, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h10);
        fetch_cycle(1'b1);
        do_instr(32'hB400_0100, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8);
        fetch_cycle(1'b1);
        do_instr(32'h1400_003D, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h3D);
        fetch_cycle(1'b1);

        // Backward B at 0x100 with a stalled decoder and a stray resolution pulse.
        do_instr(32'h17FF_FFFE, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        fetch_cycle(1'b0);
        do_instr(32'h17FF_FFD2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFD2);
        fetch_cycle(1'b1);

        // CBZ at 0x40, taken then not taken.
        do_instr(32'hB400_0060, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h3);
        fetch_cycle(1'b1);
        do_instr(32'h17FF_FFFD, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        fetch_cycle(1'b1);
        do_instr(32'hB400_0060, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h3);
        fetch_cycle(1'b1);

        // Jump to the top of the address space, then wrap while retired is saturated.
        do_instr(32'h17FF_FFEE, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEE);
        fetch_cycle(1'b1);
        do_instr(32'h8B02_0020, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5);
        fetch_cycle(1'b1);

        // Reset during WAIT; a late rvalid in the first post-reset cycle must be dropped.
        step();
        Reset = 1'b1;
        step();
        check_reset_outputs();
        exp_q.push_back(64'h0);
        ret_exp    = 32'h0;
        last_valid = 1'b0;
        @(posedge CLK);
        #1;
        Reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        fetch_cycle(1'b0);
        do_instr(32'h9100_0421, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7);
        fetch_cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
